id_ex_stage: RTL

- Decode-to-execute pipeline register sitting directly downstream of the register file.
- Captures the two register-file read ports together with decode payload, using a valid/ready handshake.
- Resolves the same-cycle writeback/read hazard by bypassing the writeback data. The register file writes at the clock edge, so a same-cycle read would otherwise see the stale value.
- Detects load-use hazards, inserts one bubble, and accepts a flush from branch resolution.

---
 rtl/id_ex_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with same-cycle writeback bypass,
// load-use bubble insertion, flush, and operand snoop while stalled.
module id_ex_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CTRL_W   = 16,
    parameter int unsigned LOAD_BIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic              ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q,    ex_pc_d;
    logic [XLEN-1:0]   ex_imm_q,   ex_imm_d;
    logic [XLEN-1:0]   ex_op1_q,   ex_op1_d;
    logic [XLEN-1:0]   ex_op2_q,   ex_op2_d;
    logic [4:0]        ex_rs1_q,   ex_rs1_d;
    logic [4:0]        ex_rs2_q,   ex_rs2_d;
    logic [4:0]        ex_rd_q,    ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;

    logic [XLEN-1:0]   op1_n, op2_n;
    logic              advance, hazard;

    always_comb begin
        // x0 reads as zero; a same-cycle writeback wins over the stale RF read.
        if (id_rs1 == 5'd0)
            op1_n = '0;
        else if (wb_reg_write && wb_rd == id_rs1)
            op1_n = wb_wd;
        else
            op1_n = rf_rd1;

        if (id_rs2 == 5'd0)
            op2_n = '0;
        else if (wb_reg_write && wb_rd == id_rs2)
            op2_n = wb_wd;
        else
            op2_n = rf_rd2;

        advance  = !ex_valid_q || ex_ready;
        hazard   = ex_valid_q && ex_ctrl_q[LOAD_BIT] && (ex_rd_q != 5'd0) &&
                   ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
        id_ready = advance && !hazard;

        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_imm_d   = ex_imm_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        ex_ctrl_d  = ex_ctrl_q;

        if (flush || (advance && hazard)) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (advance) begin
            ex_valid_d = id_valid;
            ex_pc_d    = id_pc;
            ex_imm_d   = id_imm;
            ex_op1_d   = op1_n;
            ex_op2_d   = op2_n;
            ex_rs1_d   = id_rs1;
            ex_rs2_d   = id_rs2;
            ex_rd_d    = id_rd;
            ex_ctrl_d  = id_valid ? id_ctrl : '0;
        end else begin
            // Stalled: keep held operands current with writebacks behind us.
            if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1_q)
                ex_op1_d = wb_wd;
            if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2_q)
                ex_op2_d = wb_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_imm_q   <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_imm_q   <= ex_imm_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_pc    = ex_pc_q;
    assign ex_imm   = ex_imm_q;
    assign ex_op1   = ex_op1_q;
    assign ex_op2   = ex_op2_q;
    assign ex_rs1   = ex_rs1_q;
    assign ex_rs2   = ex_rs2_q;
    assign ex_rd    = ex_rd_q;
    assign ex_ctrl  = ex_ctrl_q;

endmodule
